// File: rtl/core2apb_master.sv
// -----------------------------------------------------------------------------
// core2apb_master
// Initiator end of the APB peripheral bus. It turns a core-style data request
// (req/gnt/rvalid) straight into one APB3 master transfer. Only one transfer is
// in flight at a time. A watchdog converts a slave that never raises pready
// into an error response.
//
// Parameters
//   APB_ADDR_WIDTH  width of paddr_o; the low bits of data_addr_i are used
//   APB_DATA_WIDTH  APB data width; only 32 is a legal value
//   TIMEOUT_CYCLES  ACCESS cycles tolerated without pready (0 = no watchdog)
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   data_req_i / data_gnt_o       request and combinational grant
//   data_rvalid_o                 one-cycle response strobe per granted request
//   data_we_i, data_be_i          direction and byte enables
//   data_addr_i, data_wdata_i     byte address and write data
//   data_rdata_o, data_err_o      response data and error, held until next response
//   paddr_o, pwdata_o, pwrite_o   APB address (word aligned), write data, direction
//   psel_o, penable_o             APB select and enable, both registered
//   prdata_i, pready_i, pslverr_i APB slave response
// -----------------------------------------------------------------------------
module core2apb_master #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      data_req_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [31:0]               data_addr_i,
   input  logic [31:0]               data_wdata_i,
   output logic [31:0]               data_rdata_o,
   output logic                      data_err_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   // The watchdog counts 0 .. TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t state;
   state_t state_next;

   logic [APB_ADDR_WIDTH-1:0] addr_q;
   logic [APB_DATA_WIDTH-1:0] wdata_q;
   logic                      we_q;
   logic [CNT_W-1:0]          wd_cnt;
   logic                      psel_q;
   logic                      penable_q;
   logic                      rvalid_q;
   logic [31:0]               rdata_q;
   logic                      err_q;

   logic grant;
   logic accept;
   logic partial_wr;
   logic xfer_done;
   logic xfer_timeout;
   logic timeout_hit;

   // The watchdog fires on the ACCESS cycle that would bring the count of
   // not-ready cycles up to TIMEOUT_CYCLES.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state and control decode. APB has no byte strobes in APB3, so a
   // write that does not cover the full word is refused at grant time
   // without touching the bus. Grant is held low while reset is asserted
   // even though the state register already sits in IDLE.
   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      accept       = 1'b0;
      partial_wr   = 1'b0;
      xfer_done    = 1'b0;
      xfer_timeout = 1'b0;
      case (state)
         IDLE: begin
            grant = data_req_i && !rst_i;
            if (grant) begin
               accept = 1'b1;
               if (data_we_i && (data_be_i != 4'hF)) begin
                  partial_wr = 1'b1;
               end else begin
                  state_next = SETUP;
               end
            end
         end
         SETUP: begin
            state_next = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               xfer_done  = 1'b1;
               state_next = IDLE;
            end else if (timeout_hit) begin
               xfer_timeout = 1'b1;
               state_next   = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // psel/penable are computed from the next state and registered, so pready
   // only ever reaches the APB outputs through a flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
      end else begin
         psel_q    <= (state_next == SETUP) || (state_next == ACCESS);
         penable_q <= (state_next == ACCESS);
      end
   end

   // Request capture. The address is kept at full width; alignment is
   // applied on the way out to the bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= data_addr_i[APB_ADDR_WIDTH-1:0];
         wdata_q <= data_wdata_i;
         we_q    <= data_we_i;
      end
   end

   // Watchdog: cleared while in SETUP so every ACCESS phase starts from zero,
   // then advanced on each ACCESS cycle the slave stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_cnt <= '0;
      end else if (state == SETUP) begin
         wd_cnt <= '0;
      end else if ((state == ACCESS) && !pready_i) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   // Response path. rvalid is a one-cycle strobe after the transfer ends;
   // data and error stay put between responses. A completed transfer takes
   // priority over the watchdog because xfer_done is decoded first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         if (partial_wr || xfer_timeout) begin
            rvalid_q <= 1'b1;
            rdata_q  <= '0;
            err_q    <= 1'b1;
         end else if (xfer_done) begin
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? 32'h0 : prdata_i;
            err_q    <= pslverr_i;
         end
      end
   end

   assign data_gnt_o    = grant;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign data_err_o    = err_q;
   assign paddr_o       = addr_q & ~APB_ADDR_WIDTH'(3);
   assign pwdata_o      = wdata_q;
   assign pwrite_o      = we_q;
   assign psel_o        = psel_q;
   assign penable_o     = penable_q;

endmodule

// File: tb/tb_core2apb_master.sv
// -----------------------------------------------------------------------------
// tb_core2apb_master
// Drives core-side requests into core2apb_master and plays the APB slave.
// Expected bus activity and responses come from the transfer rules: a partial
// write is refused with an error, otherwise SETUP then ACCESS until pready or
// the watchdog, with the response one cycle later.
// -----------------------------------------------------------------------------
module tb_core2apb_master;

   localparam int AW      = 12;
   localparam int TIMEOUT = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          data_req_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_addr_i;
   logic [31:0]   data_wdata_i;
   logic [31:0]   data_rdata_o;
   logic          data_err_o;
   logic [AW-1:0] paddr_o;
   logic [31:0]   pwdata_o;
   logic          pwrite_o;
   logic          psel_o;
   logic          penable_o;
   logic [31:0]   prdata_i;
   logic          pready_i;
   logic          pslverr_i;

   int total = 0;
   int bad   = 0;

   // Response values the core should currently see on rdata/err.
   logic [31:0] exp_rdata;
   logic        exp_err;

   core2apb_master #(
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .data_req_i   (data_req_i),
      .data_gnt_o   (data_gnt_o),
      .data_rvalid_o(data_rvalid_o),
      .data_we_i    (data_we_i),
      .data_be_i    (data_be_i),
      .data_addr_i  (data_addr_i),
      .data_wdata_i (data_wdata_i),
      .data_rdata_o (data_rdata_o),
      .data_err_o   (data_err_o),
      .paddr_o      (paddr_o),
      .pwdata_o     (pwdata_o),
      .pwrite_o     (pwrite_o),
      .psel_o       (psel_o),
      .penable_o    (penable_o),
      .prdata_i     (prdata_i),
      .pready_i     (pready_i),
      .pslverr_i    (pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One idle cycle with no request: no response strobe, response held.
   task automatic idleCycle();
      @(negedge clk_i);
      checkOutput("idle_rvalid", data_rvalid_o, 1'b0);
      checkOutput("idle_rdata",  data_rdata_o,  exp_rdata);
      checkOutput("idle_err",    data_err_o,    exp_err);
      checkOutput("idle_psel",   psel_o,        1'b0);
   endtask

   // Issues one request starting at the current negedge (DUT must be IDLE),
   // acts as the slave with 'waits' not-ready ACCESS cycles, and returns at
   // the negedge of the response cycle so the caller may chain a request.
   task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input int waits,
                                input logic [31:0] rd, input logic se);
      bit          partial;
      bit          tout;
      int          n_acc;
      logic [31:0] exp_addr;
      partial  = we && (be != 4'hF);
      tout     = !partial && (waits >= TIMEOUT);
      n_acc    = tout ? TIMEOUT : waits + 1;
      exp_addr = {20'h0, addr[AW-1:0]} & 32'hFFFF_FFFC;

      data_req_i   = 1'b1;
      data_we_i    = we;
      data_be_i    = be;
      data_addr_i  = addr;
      data_wdata_i = wdata;
      pready_i     = 1'b0;
      #1;
      checkOutput("gnt_idle", data_gnt_o, 1'b1);
      @(posedge clk_i);
      #1;
      // Scramble the request inputs: the bus must use the captured copy.
      data_req_i   = 1'b0;
      data_we_i    = 1'($urandom);
      data_be_i    = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;

      if (partial) begin
         @(negedge clk_i);
         exp_rdata = 32'h0;
         exp_err   = 1'b1;
         checkOutput("partial_psel",   psel_o,        1'b0);
         checkOutput("partial_rvalid", data_rvalid_o, 1'b1);
         checkOutput("partial_err",    data_err_o,    exp_err);
         checkOutput("partial_rdata",  data_rdata_o,  exp_rdata);
         return;
      end

      @(negedge clk_i);
      checkOutput("setup_psel",    psel_o,        1'b1);
      checkOutput("setup_penable", penable_o,     1'b0);
      checkOutput("setup_paddr",   paddr_o,       exp_addr);
      checkOutput("setup_pwrite",  pwrite_o,      we);
      checkOutput("setup_rvalid",  data_rvalid_o, 1'b0);
      if (we) checkOutput("setup_pwdata", pwdata_o, wdata);
      data_req_i = 1'b1;
      #1;
      checkOutput("gnt_busy", data_gnt_o, 1'b0);
      data_req_i = 1'b0;

      for (int i = 0; i < n_acc; i++) begin
         @(negedge clk_i);
         checkOutput("access_psel",    psel_o,        1'b1);
         checkOutput("access_penable", penable_o,     1'b1);
         checkOutput("access_paddr",   paddr_o,       exp_addr);
         checkOutput("access_pwrite",  pwrite_o,      we);
         checkOutput("access_rvalid",  data_rvalid_o, 1'b0);
         if (we) checkOutput("access_pwdata", pwdata_o, wdata);
         if (!tout && (i == waits)) begin
            pready_i  = 1'b1;
            prdata_i  = rd;
            pslverr_i = se;
         end else begin
            pready_i  = 1'b0;
            prdata_i  = $urandom;
            pslverr_i = 1'($urandom);
         end
      end
      @(posedge clk_i);
      #1;
      pready_i  = 1'b0;
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);

      @(negedge clk_i);
      exp_err   = tout ? 1'b1 : se;
      exp_rdata = (tout || we) ? 32'h0 : rd;
      checkOutput("resp_psel",    psel_o,        1'b0);
      checkOutput("resp_penable", penable_o,     1'b0);
      checkOutput("resp_rvalid",  data_rvalid_o, 1'b1);
      checkOutput("resp_err",     data_err_o,    exp_err);
      checkOutput("resp_rdata",   data_rdata_o,  exp_rdata);
   endtask

   initial begin
      logic        r_we;
      logic [3:0]  r_be;
      int          r_waits;

      rst_i        = 1'b1;
      data_req_i   = 1'b1;
      data_we_i    = 1'b0;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      prdata_i     = 32'h0;
      pready_i     = 1'b0;
      pslverr_i    = 1'b0;
      exp_rdata    = 32'h0;
      exp_err      = 1'b0;

      // Reset values, with a request pending that must not be granted.
      #1;
      checkOutput("rst_gnt",     data_gnt_o,    1'b0);
      checkOutput("rst_psel",    psel_o,        1'b0);
      checkOutput("rst_penable", penable_o,     1'b0);
      checkOutput("rst_pwrite",  pwrite_o,      1'b0);
      checkOutput("rst_rvalid",  data_rvalid_o, 1'b0);
      checkOutput("rst_paddr",   paddr_o,       32'h0);
      checkOutput("rst_pwdata",  pwdata_o,      32'h0);
      checkOutput("rst_rdata",   data_rdata_o,  32'h0);
      checkOutput("rst_err",     data_err_o,    1'b0);
      data_req_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      idleCycle();

      // Zero-wait read.
      applyStimulus(1'b0, 4'hF, 32'h1A10_1008, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
      idleCycle();

      // Write with three wait states.
      applyStimulus(1'b1, 4'hF, 32'h1A10_0004, 32'h0000_00FF, 3, 32'h0, 1'b0);
      idleCycle();

      // Partial write is refused.
      applyStimulus(1'b1, 4'h3, 32'h1A10_0010, 32'h1234_5678, 0, 32'h0, 1'b0);
      idleCycle();

      // Slave error on a read, then a request granted in the response cycle.
      applyStimulus(1'b0, 4'hF, 32'h1A10_200C, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
      applyStimulus(1'b0, 4'h0, 32'h1A10_2010, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
      idleCycle();

      // Slave never ready: watchdog error.
      applyStimulus(1'b0, 4'hF, 32'h1A10_3000, 32'h0, 100, 32'h5555_AAAA, 1'b0);
      idleCycle();

      // Ready on the very cycle the watchdog would fire: ready wins.
      applyStimulus(1'b0, 4'hF, 32'h1A10_3004, 32'h0, TIMEOUT - 1, 32'h7777_1111, 1'b0);
      idleCycle();

      // Reset in the middle of ACCESS aborts the transfer.
      data_req_i  = 1'b1;
      data_we_i   = 1'b0;
      data_be_i   = 4'hF;
      data_addr_i = 32'h1A10_4008;
      @(posedge clk_i);
      #1;
      data_req_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("pre_rst_penable", penable_o, 1'b1);
      rst_i = 1'b1;
      #1;
      checkOutput("async_rst_psel",    psel_o,        1'b0);
      checkOutput("async_rst_penable", penable_o,     1'b0);
      checkOutput("async_rst_rvalid",  data_rvalid_o, 1'b0);
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      checkOutput("async_rst_rdata",   data_rdata_o,  exp_rdata);
      checkOutput("async_rst_err",     data_err_o,    exp_err);
      @(negedge clk_i);
      rst_i = 1'b0;
      idleCycle();
      idleCycle();
      applyStimulus(1'b0, 4'hF, 32'h1A10_4008, 32'h0, 0, 32'h0246_8ACE, 1'b0);
      idleCycle();

      // Randomized transfers, sometimes chained into the response cycle.
      for (int n = 0; n < 40; n++) begin
         r_we = 1'($urandom);
         if ($urandom_range(0, 3) == 0) r_be = 4'($urandom_range(0, 14));
         else r_be = 4'hF;
         r_waits = $urandom_range(0, TIMEOUT + 1);
         applyStimulus(r_we, r_be, $urandom, $urandom, r_waits, $urandom, 1'($urandom));
         if ($urandom_range(0, 1) == 0) idleCycle();
      end
      idleCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
